// File: rtl/connect4_pkg.sv
// Shared Connect4 constants and helpers: board defaults, ceil-log2 and
// extraction of one column count from a packed count vector.
package connect4_pkg;

  localparam int DEF_NUM_COLS = 7;
  localparam int DEF_ROWS     = 6;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Returns column idx of a packed count vector whose fields are cnt_w wide.
  function automatic int count_slice(input logic [255:0] packed_cnt,
                                     input int idx, input int cnt_w);
    logic [255:0] shifted;
    shifted = packed_cnt >> (idx * cnt_w);
    return int'(shifted[31:0] & ((32'd1 << cnt_w) - 32'd1));
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: the previous level is loaded even during reset, so a
// level held high across reset release yields no pulse.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic in_sig,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  // Next previous-level is simply the current input.
  always_comb begin
    prev_d = in_sig;
  end

  // Previous-level register; reset loads the live input instead of clearing.
  always_ff @(posedge clk) begin
    if (reset) prev_q <= in_sig;
    else       prev_q <= prev_d;
  end

  assign rise = in_sig & ~prev_q;

endmodule

// File: rtl/column_fill_counter.sv
// Per-column fill counter for the Connect4 board. Accepts one-hot active-low
// column selects with edge-detected add/remove requests, tracks each column
// height, reports the landing row and pulses move_ok / move_err for one cycle.
module column_fill_counter
  import connect4_pkg::*;
#(
  parameter  int NUM_COLS = DEF_NUM_COLS,
  parameter  int ROWS     = DEF_ROWS,
  localparam int CNT_W    = clog2(ROWS + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_COLS-1:0]       column,
  input  logic                      add,
  input  logic                      remove,
  output logic [NUM_COLS*CNT_W-1:0] count,
  output logic [CNT_W-1:0]          land_row,
  output logic                      move_ok,
  output logic                      move_err,
  output logic [NUM_COLS-1:0]       col_full,
  output logic                      board_full
);

  localparam logic [CNT_W-1:0] ROWS_C = CNT_W'(ROWS);

  logic                      add_ev;
  logic                      rem_ev;
  logic [NUM_COLS*CNT_W-1:0] count_flat;
  logic [NUM_COLS*CNT_W-1:0] count_d;
  logic [CNT_W-1:0]          land_row_q, land_row_d;
  logic                      move_ok_q, move_ok_d;
  logic                      move_err_q, move_err_d;
  int                        zero_cnt;
  int                        sel_base;
  logic                      sel_valid;
  logic [CNT_W-1:0]          cur;

  rise_detect u_add_rise (
    .clk    (clk),
    .reset  (reset),
    .in_sig (add),
    .rise   (add_ev)
  );

  rise_detect u_rem_rise (
    .clk    (clk),
    .reset  (reset),
    .in_sig (remove),
    .rise   (rem_ev)
  );

  // Decode the select, judge legality of the event and compute next state.
  always_comb begin
    count_d    = count_flat;
    land_row_d = land_row_q;
    move_ok_d  = 1'b0;
    move_err_d = 1'b0;
    zero_cnt   = 0;
    sel_base   = 0;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (!column[i]) begin
        zero_cnt = zero_cnt + 1;
        sel_base = i * CNT_W;
      end
    end
    sel_valid = (zero_cnt == 1);
    cur       = count_flat[sel_base +: CNT_W];
    if (add_ev && rem_ev) begin
      move_err_d = 1'b1;
    end else if (add_ev) begin
      if (sel_valid && (cur < ROWS_C)) begin
        count_d[sel_base +: CNT_W] = cur + CNT_W'(1);
        land_row_d                 = cur;
        move_ok_d                  = 1'b1;
      end else begin
        move_err_d = 1'b1;
      end
    end else if (rem_ev) begin
      if (sel_valid && (cur != '0)) begin
        count_d[sel_base +: CNT_W] = cur - CNT_W'(1);
        land_row_d                 = cur - CNT_W'(1);
        move_ok_d                  = 1'b1;
      end else begin
        move_err_d = 1'b1;
      end
    end
  end

  // One counter register per column plus its full flag.
  for (genvar g = 0; g < NUM_COLS; g++) begin : g_col
    logic [CNT_W-1:0] cnt_q;

    // Column height register.
    always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= count_d[g*CNT_W +: CNT_W];
    end

    assign count_flat[g*CNT_W +: CNT_W] = cnt_q;
    assign col_full[g]                  = (cnt_q == ROWS_C);
  end

  // Landing row and one-cycle result pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      land_row_q <= '0;
      move_ok_q  <= 1'b0;
      move_err_q <= 1'b0;
    end else begin
      land_row_q <= land_row_d;
      move_ok_q  <= move_ok_d;
      move_err_q <= move_err_d;
    end
  end

  assign count      = count_flat;
  assign land_row   = land_row_q;
  assign move_ok    = move_ok_q;
  assign move_err   = move_err_q;
  assign board_full = &col_full;

endmodule

// File: tb/tb_column_fill_counter.sv
// Bench for column_fill_counter (7 columns x 6 rows): a hand-derived vector
// table, directed corner sequences and random traffic against a move-level
// reference model.
module tb_column_fill_counter;

  logic        clk;
  logic        reset;
  logic [6:0]  column;
  logic        add;
  logic        remove;
  logic [20:0] count;
  logic [2:0]  land_row;
  logic        move_ok;
  logic        move_err;
  logic [6:0]  col_full;
  logic        board_full;

  int n_cmp;
  int n_bad;

  // Reference model state: column heights, last result, previous request levels.
  int   m_cnt [7];
  int   m_land;
  logic m_ok;
  logic m_err;
  logic m_add_prev;
  logic m_rem_prev;

  typedef struct {
    logic [6:0] col;
    logic       a;
    logic       r;
    logic       ok;
    logic       err;
    logic [2:0] land;
  } vec_t;

  vec_t tbl [14];

  localparam logic [6:0] C0   = 7'b1111110;
  localparam logic [6:0] C1   = 7'b1111101;
  localparam logic [6:0] C3   = 7'b1110111;
  localparam logic [6:0] C5   = 7'b1011111;
  localparam logic [6:0] NONE = 7'b1111111;
  localparam logic [6:0] TWO  = 7'b1110110;

  column_fill_counter dut (
    .clk        (clk),
    .reset      (reset),
    .column     (column),
    .add        (add),
    .remove     (remove),
    .count      (count),
    .land_row   (land_row),
    .move_ok    (move_ok),
    .move_err   (move_err),
    .col_full   (col_full),
    .board_full (board_full)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply the move rules to one sampled clock edge.
  task automatic model_step(input logic [6:0] c, input logic a, input logic r, input logic rs);
    logic ae;
    logic re;
    int   nz;
    int   idx;
    if (rs) begin
      for (int i = 0; i < 7; i++) m_cnt[i] = 0;
      m_land = 0;
      m_ok   = 1'b0;
      m_err  = 1'b0;
    end else begin
      ae    = a && !m_add_prev;
      re    = r && !m_rem_prev;
      m_ok  = 1'b0;
      m_err = 1'b0;
      nz    = 0;
      idx   = 0;
      for (int i = 0; i < 7; i++) begin
        if (c[i] == 1'b0) begin
          nz  = nz + 1;
          idx = i;
        end
      end
      if (ae && re) begin
        m_err = 1'b1;
      end else if (ae) begin
        if (nz == 1 && m_cnt[idx] < 6) begin
          m_land     = m_cnt[idx];
          m_cnt[idx] = m_cnt[idx] + 1;
          m_ok       = 1'b1;
        end else m_err = 1'b1;
      end else if (re) begin
        if (nz == 1 && m_cnt[idx] > 0) begin
          m_cnt[idx] = m_cnt[idx] - 1;
          m_land     = m_cnt[idx];
          m_ok       = 1'b1;
        end else m_err = 1'b1;
      end
    end
    m_add_prev = a;
    m_rem_prev = r;
  endtask

  task automatic check_model();
    logic [20:0] exp_cnt;
    logic [6:0]  exp_full;
    for (int i = 0; i < 7; i++) begin
      exp_cnt[i*3 +: 3] = 3'(m_cnt[i]);
      exp_full[i]       = (m_cnt[i] == 6);
    end
    check("count", 32'(count), 32'(exp_cnt));
    check("land_row", 32'(land_row), 32'(m_land));
    check("move_ok", 32'(move_ok), 32'(m_ok));
    check("move_err", 32'(move_err), 32'(m_err));
    check("col_full", 32'(col_full), 32'(exp_full));
    check("board_full", 32'(board_full), 32'(&exp_full));
  endtask

  // Drive one cycle of inputs, advance the model at the edge, compare 1ns later.
  task automatic tick(input logic [6:0] c, input logic a, input logic r, input logic rs);
    column = c;
    add    = a;
    remove = r;
    reset  = rs;
    @(posedge clk);
    model_step(c, a, r, rs);
    #1;
    check_model();
  endtask

  task automatic set_vec(input int i, input logic [6:0] c, input logic a, input logic r,
                         input logic ok, input logic err, input logic [2:0] land);
    tbl[i].col  = c;
    tbl[i].a    = a;
    tbl[i].r    = r;
    tbl[i].ok   = ok;
    tbl[i].err  = err;
    tbl[i].land = land;
  endtask

  function automatic logic [6:0] rand_col();
    if ($urandom_range(0, 3) == 0) return 7'($urandom_range(0, 127));
    return ~(7'b1 << $urandom_range(0, 6));
  endfunction

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    m_add_prev = 1'b0;
    m_rem_prev = 1'b0;
    column     = NONE;
    add        = 1'b0;
    remove     = 1'b0;
    reset      = 1'b1;

    set_vec(0,  C0,   1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
    set_vec(1,  C0,   1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    set_vec(2,  C0,   1'b1, 1'b0, 1'b1, 1'b0, 3'd1);
    set_vec(3,  C0,   1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
    set_vec(4,  C0,   1'b1, 1'b0, 1'b1, 1'b0, 3'd2);
    set_vec(5,  C0,   1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
    set_vec(6,  NONE, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2);
    set_vec(7,  NONE, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
    set_vec(8,  TWO,  1'b1, 1'b0, 1'b0, 1'b1, 3'd2);
    set_vec(9,  TWO,  1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
    set_vec(10, C0,   1'b1, 1'b1, 1'b0, 1'b1, 3'd2);
    set_vec(11, C0,   1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
    set_vec(12, C0,   1'b0, 1'b1, 1'b1, 1'b0, 3'd2);
    set_vec(13, C0,   1'b0, 1'b0, 1'b0, 1'b0, 3'd2);

    // Reset state.
    tick(NONE, 1'b0, 1'b0, 1'b1);
    tick(NONE, 1'b0, 1'b0, 1'b1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_land", 32'(land_row), 32'd0);
    check("rst_full", 32'({board_full, col_full}), 32'd0);
    tick(NONE, 1'b0, 1'b0, 1'b0);

    // Vector table: three adds to column 0, bad selects, add+remove, one remove.
    for (int i = 0; i < 14; i++) begin
      tick(tbl[i].col, tbl[i].a, tbl[i].r, 1'b0);
      check($sformatf("tbl%0d_ok", i), 32'(move_ok), 32'(tbl[i].ok));
      check($sformatf("tbl%0d_err", i), 32'(move_err), 32'(tbl[i].err));
      check($sformatf("tbl%0d_land", i), 32'(land_row), 32'(tbl[i].land));
      if (i == 5) check("tbl_cnt0_3", 32'(count[2:0]), 32'd3);
    end
    check("tbl_cnt0_2", 32'(count[2:0]), 32'd2);
    check("tbl_others", 32'(count[20:3]), 32'd0);

    // Fill column 3, then overflow attempt.
    tick(NONE, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      tick(C3, 1'b1, 1'b0, 1'b0);
      tick(C3, 1'b0, 1'b0, 1'b0);
    end
    tick(C3, 1'b1, 1'b0, 1'b0);
    check("full_err", 32'(move_err), 32'd1);
    check("full_cnt3", 32'(count[11:9]), 32'd6);
    check("full_flag3", 32'(col_full[3]), 32'd1);
    check("full_board", 32'(board_full), 32'd0);
    tick(C3, 1'b0, 1'b0, 1'b0);

    // Remove on empty column 5, then two adds and a remove.
    tick(C5, 1'b0, 1'b1, 1'b0);
    check("empty_err", 32'(move_err), 32'd1);
    tick(C5, 1'b0, 1'b0, 1'b0);
    tick(C5, 1'b1, 1'b0, 1'b0);
    tick(C5, 1'b0, 1'b0, 1'b0);
    tick(C5, 1'b1, 1'b0, 1'b0);
    tick(C5, 1'b0, 1'b0, 1'b0);
    tick(C5, 1'b0, 1'b1, 1'b0);
    check("rem_cnt5", 32'(count[17:15]), 32'd1);
    check("rem_land", 32'(land_row), 32'd1);
    check("rem_ok", 32'(move_ok), 32'd1);
    tick(C5, 1'b0, 1'b0, 1'b0);

    // Add held high for 10 cycles gives a single increment.
    for (int k = 0; k < 10; k++) tick(C1, 1'b1, 1'b0, 1'b0);
    tick(C1, 1'b0, 1'b0, 1'b0);
    check("held_cnt1", 32'(count[5:3]), 32'd1);

    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      tick(rand_col(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 79) == 0));
    end

    // Fill the whole board.
    tick(NONE, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 7; c++) begin
      for (int r = 0; r < 6; r++) begin
        tick(~(7'b1 << c), 1'b1, 1'b0, 1'b0);
        if (c == 6 && r == 4) check("board_41", 32'(board_full), 32'd0);
        tick(~(7'b1 << c), 1'b0, 1'b0, 1'b0);
      end
    end
    check("board_42", 32'(board_full), 32'd1);
    check("board_cnt", 32'(count), 32'(21'o6666666));

    // Add held through reset release produces no event until it re-rises.
    tick(C0, 1'b1, 1'b0, 1'b1);
    tick(C0, 1'b1, 1'b0, 1'b1);
    tick(C0, 1'b1, 1'b0, 1'b0);
    check("rel_ok", 32'(move_ok), 32'd0);
    check("rel_cnt", 32'(count), 32'd0);
    tick(C0, 1'b1, 1'b0, 1'b0);
    tick(C0, 1'b0, 1'b0, 1'b0);
    tick(C0, 1'b1, 1'b0, 1'b0);
    check("rerise_ok", 32'(move_ok), 32'd1);
    check("rerise_cnt", 32'(count[2:0]), 32'd1);
    tick(C0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
